// File: rtl/spi_display_target.sv
// SPI mode-0 display target: oversampled SPI inputs, byte assembly with a
// data/command tag, show-ahead receive FIFO with sticky overflow, and a
// response byte shifted out on MISO.
module spi_display_target #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       display_csb,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       frame_abort,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    // bit order in each stage: {spi_clk, csb, mosi, dc}
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic sclk_s, csb_s, mosi_s, dc_s;
    logic sclk_prev_q, armed_q;
    logic rise, fall;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        push_q, push_d;
    logic [8:0]  push_ent_q, push_ent_d;
    logic        abort_q, abort_d;

    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        overflow_q;
    logic        full, empty, pop, wr_en, ovf_evt;

    assign sclk_s = sync_q[SYNC_STAGES-1][3];
    assign csb_s  = sync_q[SYNC_STAGES-1][2];
    assign mosi_s = sync_q[SYNC_STAGES-1][1];
    assign dc_s   = sync_q[SYNC_STAGES-1][0];

    assign rise = sclk_s & ~sclk_prev_q;
    assign fall = ~sclk_s & sclk_prev_q;

    // armed_q blocks a frame that was already in progress when reset released:
    // csb must be seen high once before a low csb counts as a frame
    assign busy = armed_q & ~csb_s;

    // input synchronizer chain for all four SPI-side signals
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], {spi_clk, display_csb, spi_mosi, data_commandb}};
    end

    // delayed spi_clk for edge detection, and csb-high arming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            if (csb_s) armed_q <= 1'b1;
        end
    end

    // frame FSM and shifter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            push_q     <= push_d;
            push_ent_q <= push_ent_d;
            abort_q    <= abort_d;
        end
    end

    // next-state: bit shifting on SPI edges, byte completion, abort detection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        push_d     = 1'b0;
        push_ent_d = push_ent_q;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (busy) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    tx_sh_d = tx_data;
                end
            end
            SHIFT: begin
                if (!busy) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    abort_d = (cnt_q != 3'd0);
                end else if (rise) begin
                    rx_sh_d = {rx_sh_q[6:0], mosi_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        push_d     = 1'b1;
                        push_ent_d = {dc_s, rx_sh_q[6:0], mosi_s};
                    end
                end else if (fall) begin
                    // counter zero on a falling edge means a byte boundary
                    if (cnt_q != 3'd0) tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    else               tx_sh_d = tx_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso    = (state_q == SHIFT) & tx_sh_q[7];
    assign frame_abort = abort_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rx_valid = ~empty;
    assign pop     = rx_valid & rx_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en   = push_q & (~full | pop);
    assign ovf_evt = push_q & full & ~pop;

    assign rx_data = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign rx_dc   = mem_q[rd_ptr_q[AW-1:0]][8];
    assign overflow = overflow_q;

    // receive FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_ent_q;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            overflow_q <= ovf_evt | (overflow_q & ~overflow_clr);
        end
    end
endmodule
